// File: rtl/fifo_1_if.sv
// Producer/consumer handshake bundle for fifo_1: write side (wdata/winc/wfull)
// and first-word fall-through read side (rinc/rdata/rempty).
interface fifo_1_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;

  modport master (
    output wdata, winc, rinc,
    input  wfull, rdata, rempty
  );

  modport slave (
    input  wdata, winc, rinc,
    output wfull, rdata, rempty
  );
endinterface

// File: rtl/fifo_1.sv
// Single-clock FWFT FIFO, 2**ASIZE x DSIZE, with exact registered full/empty
// flags derived from the next-state pointers.
module fifo_1 #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  fifo_1_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ASIZE;
  localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_next, rptr_next;
  logic             wfull_q, rempty_q;
  logic             wfull_next, rempty_next;
  logic             we, re;

  assign we = bus.winc & ~wfull_q;
  assign re = bus.rinc & ~rempty_q;

  always_comb begin
    wptr_next = wptr;
    rptr_next = rptr;
    if (we) wptr_next = wptr + PTR_ONE;
    if (re) rptr_next = rptr + PTR_ONE;
  end

  // Wrap bit differs with equal addresses: the writer is a full lap ahead.
  always_comb begin
    rempty_next = (wptr_next == rptr_next);
    wfull_next  = (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                  (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wptr     <= wptr_next;
      rptr     <= rptr_next;
      wfull_q  <= wfull_next;
      rempty_q <= rempty_next;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr[ASIZE-1:0]] <= bus.wdata;
  end

  assign bus.rdata  = mem[rptr[ASIZE-1:0]];
  assign bus.wfull  = wfull_q;
  assign bus.rempty = rempty_q;
endmodule

// File: tb/tb_fifo_1.sv
// Scoreboard bench for fifo_1: a reference queue models occupancy, acceptance
// and read order; rdata is checked before each pop, flags after each edge.
module tb_fifo_1;
  localparam int DSIZE = 8;
  localparam int ASIZE = 5;
  localparam int DEPTH = 2 ** ASIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DSIZE-1:0] sb [$];

  fifo_1_if #(.DSIZE(DSIZE)) bus ();

  fifo_1 #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; returns whether the write was accepted.
  task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r, output logic w_ok);
    logic r_ok;
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = r;
    @(negedge clk);
    w_ok = w && (sb.size() < DEPTH);
    r_ok = r && (sb.size() > 0);
    if (r_ok) check("rdata", 32'(bus.rdata), 32'(sb[0]));
    @(posedge clk);
    #1;
    if (r_ok) void'(sb.pop_front());
    if (w_ok) sb.push_back(d);
    check("rempty", 32'(bus.rempty), 32'(sb.size() == 0));
    check("wfull", 32'(bus.wfull), 32'(sb.size() == DEPTH));
  endtask

  task automatic burst(input int n_writes);
    int wl;
    int cyc;
    logic ok;
    logic [DSIZE-1:0] pend;
    wl   = n_writes;
    cyc  = 0;
    pend = DSIZE'($urandom);
    while ((wl > 0 || sb.size() > 0) && cyc < 5000) begin
      step(wl > 0, pend, cyc[0], ok);
      if (ok) begin
        wl--;
        pend = DSIZE'($urandom);
      end
      cyc++;
    end
    check("burst_timeout", 32'(cyc < 5000), 32'd1);
  endtask

  task automatic drain();
    logic ok;
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      step(1'b0, '0, 1'b1, ok);
      guard++;
    end
    check("drain_timeout", 32'(guard < 100), 32'd1);
  endtask

  initial begin
    logic ok;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;

    // Reset held for 5 cycles
    repeat (5) @(posedge clk);
    #1;
    check("rst_rempty", 32'(bus.rempty), 32'd1);
    check("rst_wfull", 32'(bus.wfull), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, overflow attempt, ordered drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, DSIZE'(i), 1'b0, ok);
    step(1'b1, 8'hAA, 1'b0, ok);
    check("ovf_dropped", 32'(ok), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, ok);
    step(1'b0, '0, 1'b1, ok);

    // Backpressured random bursts: 120 then 25 more
    burst(120);
    burst(25);

    // Simultaneous write+read while full: read wins, write dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, DSIZE'(i + 8'h40), 1'b0, ok);
    step(1'b1, 8'hEE, 1'b1, ok);
    check("full_rw_dropped", 32'(ok), 32'd0);
    drain();

    // Simultaneous write+read while empty: write wins
    step(1'b1, 8'h5A, 1'b1, ok);
    check("empty_rw_rdata", 32'(bus.rdata), 32'h5A);
    drain();

    // Asynchronous reset mid-burst
    for (int i = 0; i < 10; i++) step(1'b1, DSIZE'($urandom), i[0], ok);
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rempty", 32'(bus.rempty), 32'd1);
    check("async_wfull", 32'(bus.wfull), 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h33, 1'b0, ok);
    step(1'b0, '0, 1'b1, ok);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
